// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, frame sizes, parity helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Odd parity over data plus parity bit: the total count of ones must be odd.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Byte delivery and status bundle between the PS/2 receiver and its consumer.
// Latency: n/a (wires only).
// Backpressure: o_valid/i_ready handshake; status pulses are not flow-controlled.
interface ps2_rx_frame_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    modport master (
        output o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy,
        input  i_ready
    );

    modport slave (
        input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun, o_busy,
        output i_ready
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one raw PS/2 pin.
// Latency: a clean pin edge shows up on level after 2+FILTER_LEN cycles.
// Backpressure: none; free-running.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level
);

    localparam int CW = $clog2(FILTER_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Synchronise, then flip level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], pin};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver; optional output FIFO selected by PS2_RX_FIFO_EN.
// Latency: byte valid the cycle after the stop-bit fall_tick (fall_tick is 2+FILTER_LEN after the pin).
// Backpressure: o_valid/i_ready; a byte arriving with no room is dropped and o_overrun pulses.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              k_clk,
    input  logic              k_data,
    ps2_rx_frame_if.master    rx
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT = 3'(PS2_DATA_BITS - 1);

    if (FILTER_LEN < 2) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic       clk_f, data_f, clk_q, fall_tick;
    ps2_state_t state;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic       par_bit;
    logic [TW-1:0] tmo_cnt;
    logic       push, pop;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (CLK_I),
        .rst   (RST_I),
        .pin   (k_clk),
        .level (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (CLK_I),
        .rst   (RST_I),
        .pin   (k_data),
        .level (data_f)
    );

    // Remember the previous filtered clock level to detect its falling edge.
    always_ff @(posedge CLK_I) begin
        if (RST_I) clk_q <= 1'b1;
        else       clk_q <= clk_f;
    end

    assign fall_tick = clk_q & ~clk_f;
    assign rx.o_busy = (state != IDLE);
    assign pop       = rx.o_valid & rx.i_ready;

    // A byte is delivered on the stop-bit tick when stop and parity both check out.
    always_comb begin
        push = 1'b0;
        if (fall_tick && state == STOP && data_f && odd_parity_ok(shreg, par_bit)) begin
            push = 1'b1;
        end
    end

    // Frame decoder with inter-edge timeout; error outputs are one-cycle registered pulses.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state           <= IDLE;
            bitcnt          <= '0;
            shreg           <= '0;
            par_bit         <= 1'b0;
            tmo_cnt         <= '0;
            rx.o_parity_err <= 1'b0;
            rx.o_frame_err  <= 1'b0;
        end else begin
            rx.o_parity_err <= 1'b0;
            rx.o_frame_err  <= 1'b0;

            if (fall_tick || state == IDLE) tmo_cnt <= '0;
            else                            tmo_cnt <= tmo_cnt + TW'(1);

            if (fall_tick) begin
                case (state)
                    IDLE: begin
                        if (!data_f) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end else begin
                            rx.o_frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg  <= {data_f, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == LAST_BIT) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_f;
                        state   <= STOP;
                    end
                    STOP: begin
                        rx.o_frame_err  <= ~data_f;
                        rx.o_parity_err <= ~odd_parity_ok(shreg, par_bit);
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tmo_cnt == TMO_MAX) begin
                state          <= IDLE;
                rx.o_frame_err <= 1'b1;
            end
        end
    end

`ifdef PS2_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, push_ok;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign push_ok    = push & (~full | pop);
    assign rx.o_valid = (count != '0);
    assign rx.o_data  = mem[rd_ptr];

    // Output FIFO: a simultaneous pop frees the slot a push into a full FIFO needs.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rx.o_overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            rx.o_overrun <= push & full & ~pop;
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
`else
    // Single holding register: keep the old byte when a new one arrives without room.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rx.o_data    <= '0;
            rx.o_valid   <= 1'b0;
            rx.o_overrun <= 1'b0;
        end else begin
            rx.o_overrun <= 1'b0;
            if (push && (!rx.o_valid || pop)) begin
                rx.o_data  <= shreg;
                rx.o_valid <= 1'b1;
            end else begin
                if (push) rx.o_overrun <= 1'b1;
                if (pop)  rx.o_valid   <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: good/bad frames, timeout, overrun, glitch, mid-frame reset.
// Latency: n/a.
// Backpressure: i_ready held low to exercise overrun/FIFO buffering.
module tb_ps2_rx_frame;

    localparam int FL  = 4;
    localparam int TMO = 300;
    localparam int H   = 20;

    logic CLK_I  = 1'b0;
    logic RST_I  = 1'b1;
    logic k_clk  = 1'b1;
    logic k_data = 1'b1;

    ps2_rx_frame_if rx();

    ps2_rx_frame #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (8)
    ) dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .k_clk  (k_clk),
        .k_data (k_data),
        .rx     (rx)
    );

    always #5 CLK_I = ~CLK_I;

    int checks   = 0;
    int failures = 0;
    int n_par    = 0;
    int n_frm    = 0;
    int n_ovr    = 0;
    int n_busy   = 0;

    // Count high cycles of each status output.
    always @(negedge CLK_I) begin
        if (!RST_I) begin
            if (rx.o_parity_err) n_par++;
            if (rx.o_frame_err)  n_frm++;
            if (rx.o_overrun)    n_ovr++;
            if (rx.o_busy)       n_busy++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    // Frame bit order: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s, input logic st);
        return {s, p, d, st};
    endfunction

    function automatic logic [10:0] good(input logic [7:0] d);
        return mk(d, ~^d, 1'b1, 1'b0);
    endfunction

    task automatic send_range(input logic [10:0] f, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            k_data = f[i];
            cyc(H);
            k_clk = 1'b0;
            cyc(H);
            k_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_range(f, 0, 10);
        k_data = 1'b1;
        cyc(5);
    endtask

    task automatic take();
        rx.i_ready = 1'b1;
        cyc(1);
        rx.i_ready = 1'b0;
        @(negedge CLK_I);
    endtask

    int p0, f0, o0, b0;

    task automatic snap();
        p0 = n_par; f0 = n_frm; o0 = n_ovr; b0 = n_busy;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rx.i_ready = 1'b0;
        cyc(4);
        @(negedge CLK_I);
        check("rst_valid", 32'(rx.o_valid), 0);
        check("rst_data",  32'(rx.o_data), 0);
        check("rst_busy",  32'(rx.o_busy), 0);
        check("rst_errs",  32'({rx.o_parity_err, rx.o_frame_err, rx.o_overrun}), 0);
        RST_I = 1'b0;
        cyc(5);

        // Good 0x1C held until consumed.
        snap();
        send_frame(good(8'h1C));
        @(negedge CLK_I);
        check("t1_valid", 32'(rx.o_valid), 1);
        check("t1_data",  32'(rx.o_data), 32'h1C);
        cyc(30);
        @(negedge CLK_I);
        check("t1_hold_valid", 32'(rx.o_valid), 1);
        check("t1_hold_data",  32'(rx.o_data), 32'h1C);
        take();
        check("t1_drop_valid", 32'(rx.o_valid), 0);
        check("t1_no_errs", n_par - p0 + n_frm - f0 + n_ovr - o0, 0);

        // Bad parity then a clean 0xF0.
        snap();
        send_frame(mk(8'h1C, 1'b1, 1'b1, 1'b0));
        @(negedge CLK_I);
        check("t2_par_pulse", n_par - p0, 1);
        check("t2_frm_none",  n_frm - f0, 0);
        check("t2_valid",     32'(rx.o_valid), 0);
        send_frame(good(8'hF0));
        @(negedge CLK_I);
        check("t2_f0_valid", 32'(rx.o_valid), 1);
        check("t2_f0_data",  32'(rx.o_data), 32'hF0);
        take();

        // Stop bit 0, then a stray start=1 while idle.
        snap();
        send_frame(mk(8'h1C, 1'b0, 1'b0, 1'b0));
        @(negedge CLK_I);
        check("t3_frm_pulse", n_frm - f0, 1);
        check("t3_par_none",  n_par - p0, 0);
        check("t3_valid",     32'(rx.o_valid), 0);
        snap();
        send_range(mk(8'hFF, 1'b1, 1'b1, 1'b1), 0, 0);
        cyc(5);
        @(negedge CLK_I);
        check("t3_idle_frm",  n_frm - f0, 1);
        check("t3_idle_busy", n_busy - b0, 0);

        // Timeout after start + 3 data bits.
        snap();
        send_range(good(8'h5A), 0, 3);
        @(negedge CLK_I);
        check("t4_busy_mid", 32'(rx.o_busy), 1);
        cyc(TMO + 10);
        @(negedge CLK_I);
        check("t4_tmo_frm",  n_frm - f0, 1);
        check("t4_tmo_busy", 32'(rx.o_busy), 0);
        check("t4_valid",    32'(rx.o_valid), 0);
        k_data = 1'b1;
        send_frame(good(8'h5A));
        @(negedge CLK_I);
        check("t4_5a_valid", 32'(rx.o_valid), 1);
        check("t4_5a_data",  32'(rx.o_data), 32'h5A);
        take();

        // Two bytes with no consumer.
        snap();
        send_frame(good(8'hF0));
        send_frame(good(8'h1C));
        @(negedge CLK_I);
        check("t5_valid",  32'(rx.o_valid), 1);
        check("t5_head",   32'(rx.o_data), 32'hF0);
`ifdef PS2_RX_FIFO_EN
        check("t5_ovr", n_ovr - o0, 0);
        take();
        check("t5_second_valid", 32'(rx.o_valid), 1);
        check("t5_second_data",  32'(rx.o_data), 32'h1C);
        take();
        check("t5_empty", 32'(rx.o_valid), 0);
`else
        check("t5_ovr", n_ovr - o0, 1);
        take();
        check("t5_empty", 32'(rx.o_valid), 0);
`endif

        // Short low glitch on k_clk in the middle of a frame.
        snap();
        send_range(good(8'h1C), 0, 4);
        k_clk = 1'b0;
        cyc(FL - 2);
        k_clk = 1'b1;
        cyc(H);
        send_range(good(8'h1C), 5, 10);
        k_data = 1'b1;
        cyc(5);
        @(negedge CLK_I);
        check("t6_valid", 32'(rx.o_valid), 1);
        check("t6_data",  32'(rx.o_data), 32'h1C);
        check("t6_errs",  n_par - p0 + n_frm - f0, 0);
        take();

        // Reset mid-frame, then a clean frame.
        send_range(good(8'hF0), 0, 5);
        @(negedge CLK_I);
        check("t7_busy_mid", 32'(rx.o_busy), 1);
        RST_I = 1'b1;
        cyc(1);
        RST_I = 1'b0;
        @(negedge CLK_I);
        check("t7_busy_rst", 32'(rx.o_busy), 0);
        k_data = 1'b1;
        cyc(10);
        snap();
        send_frame(good(8'h5A));
        @(negedge CLK_I);
        check("t7_valid", 32'(rx.o_valid), 1);
        check("t7_data",  32'(rx.o_data), 32'h5A);
        check("t7_errs",  n_par - p0 + n_frm - f0 + n_ovr - o0, 0);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
